// File: rtl/hdr_tuning_pkg.sv
// Shared tuning-word scale and encoder state encodings for the front-panel encoder and local_osc drivers.
// 2^27 tuning units = 16 MHz sample clock, so 8_388_608 = 1 MHz.
package hdr_tuning_pkg;

  localparam int PHASE_W = 27;

  localparam logic [PHASE_W-1:0] STEP      = 27'd8_389;       // 1 kHz per detent
  localparam logic [PHASE_W-1:0] TUNE_INIT = 27'd8_388_608;   // 1.000 MHz
  localparam logic [PHASE_W-1:0] TUNE_MIN  = 27'd4_445_962;   // 530 kHz
  localparam logic [PHASE_W-1:0] TUNE_MAX  = 27'd14_260_634;  // 1.7 MHz

  // Encoding is the debounced pin pair {A,B}.
  typedef enum logic [1:0] {
    ST_BOTH_LOW = 2'b00,
    ST_A_LOW    = 2'b01,
    ST_B_LOW    = 2'b10,
    ST_DETENT   = 2'b11
  } quad_state_t;

  function automatic quad_state_t cw_succ(input quad_state_t s);
    case (s)
      ST_DETENT:   return ST_B_LOW;
      ST_B_LOW:    return ST_BOTH_LOW;
      ST_BOTH_LOW: return ST_A_LOW;
      default:     return ST_DETENT;
    endcase
  endfunction

  function automatic quad_state_t ccw_succ(input quad_state_t s);
    case (s)
      ST_DETENT:   return ST_A_LOW;
      ST_A_LOW:    return ST_BOTH_LOW;
      ST_BOTH_LOW: return ST_B_LOW;
      default:     return ST_DETENT;
    endcase
  endfunction

  function automatic logic [PHASE_W-1:0] clamp_word(input logic [PHASE_W:0] v);
    if (v > {1'b0, TUNE_MAX})
      return TUNE_MAX;
    else if (v < {1'b0, TUNE_MIN})
      return TUNE_MIN;
    else
      return v[PHASE_W-1:0];
  endfunction

endpackage

// File: rtl/knob_debouncer.sv
// One encoder pin: 2-FF synchroniser followed by a hold-time debouncer.
// A new level must be seen for DEBOUNCE_CYCLES clocks before it is passed on.
module knob_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1200
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic             sync;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta  <= 1'b1;
      sync  <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      meta <= pin;
      sync <= meta;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tuning_knob_decoder.sv
// Front-panel tuning encoder: quadrature detent decoder driving a saturating NCO tuning word.
//
// state        | meaning
// ST_DETENT    | 11, encoder resting in a detent; sub-count cleared
// ST_B_LOW     | 10, first quarter CW / last quarter CCW
// ST_BOTH_LOW  | 00, half way between detents
// ST_A_LOW     | 01, last quarter CW / first quarter CCW
module tuning_knob_decoder
  import hdr_tuning_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fq_ck,
  input  logic               fq_dt,
  input  logic               preset_load,
  input  logic [PHASE_W-1:0] preset_word,
  output logic [PHASE_W-1:0] tuning_word,
  output logic               tuning_valid,
  output logic               tuning_update,
  output logic               step_cw,
  output logic               step_ccw,
  output logic               illegal
);

  logic deb_a;
  logic deb_b;

  knob_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk   (clk),
    .reset (reset),
    .pin   (fq_ck),
    .level (deb_a)
  );

  knob_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk   (clk),
    .reset (reset),
    .pin   (fq_dt),
    .level (deb_b)
  );

  quad_state_t       state;
  quad_state_t       state_nxt;
  quad_state_t       pins;
  logic signed [2:0] sub;
  logic signed [2:0] sub_nxt;
  logic              cw_move;
  logic              ccw_move;
  logic              jump;
  logic              step_cw_nxt;
  logic              step_ccw_nxt;
  logic              illegal_nxt;

  assign pins     = quad_state_t'({deb_a, deb_b});
  assign cw_move  = (pins == cw_succ(state));
  assign ccw_move = (pins == ccw_succ(state));
  assign jump     = &(state ^ pins);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_DETENT;
      sub      <= '0;
      step_cw  <= 1'b0;
      step_ccw <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      state    <= state_nxt;
      sub      <= sub_nxt;
      step_cw  <= step_cw_nxt;
      step_ccw <= step_ccw_nxt;
      illegal  <= illegal_nxt;
    end
  end

  // Sub-count stays within -3..+3 because reaching the detent always clears it.
  always_comb begin
    state_nxt = pins;
    sub_nxt   = sub;
    if (jump || (pins == ST_DETENT && state != ST_DETENT))
      sub_nxt = '0;
    else if (cw_move)
      sub_nxt = sub + 3'sd1;
    else if (ccw_move)
      sub_nxt = sub - 3'sd1;
  end

  always_comb begin
    step_cw_nxt  = cw_move  && (pins == ST_DETENT) && (sub == 3'sd3);
    step_ccw_nxt = ccw_move && (pins == ST_DETENT) && (sub == -3'sd3);
    illegal_nxt  = jump;
  end

  logic [PHASE_W:0]   sum;
  logic [PHASE_W:0]   diff;
  logic [PHASE_W-1:0] word_nxt;

  assign sum  = {1'b0, tuning_word} + {1'b0, STEP};
  assign diff = {1'b0, tuning_word} - {1'b0, STEP};

  // A preset in the same cycle as a step pulse wins; the step is dropped.
  always_comb begin
    word_nxt = tuning_word;
    if (preset_load)
      word_nxt = clamp_word({1'b0, preset_word});
    else if (step_cw)
      word_nxt = clamp_word(sum);
    else if (step_ccw)
      word_nxt = diff[PHASE_W] ? TUNE_MIN : clamp_word(diff);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tuning_word   <= TUNE_INIT;
      tuning_update <= 1'b0;
      tuning_valid  <= 1'b0;
    end else begin
      tuning_word   <= word_nxt;
      tuning_update <= (word_nxt != tuning_word);
      tuning_valid  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tuning_knob_decoder.sv
// Bench for tuning_knob_decoder: scoreboard of expected tuning words plus pulse-count checks per scenario.
module tb_tuning_knob_decoder;

  localparam int PHASE_W = 27;
  localparam int DEB     = 1200;
  localparam int HOLD    = 1300;
  localparam int LAT     = 1204;

  localparam longint W_INIT = 8388608;
  localparam longint W_MIN  = 4445962;
  localparam longint W_MAX  = 14260634;
  localparam longint W_STEP = 8389;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               fq_ck = 1'b1;
  logic               fq_dt = 1'b1;
  logic               preset_load = 1'b0;
  logic [PHASE_W-1:0] preset_word = '0;
  logic [PHASE_W-1:0] tuning_word;
  logic               tuning_valid;
  logic               tuning_update;
  logic               step_cw;
  logic               step_ccw;
  logic               illegal;

  tuning_knob_decoder #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk           (clk),
    .reset         (reset),
    .fq_ck         (fq_ck),
    .fq_dt         (fq_dt),
    .preset_load   (preset_load),
    .preset_word   (preset_word),
    .tuning_word   (tuning_word),
    .tuning_valid  (tuning_valid),
    .tuning_update (tuning_update),
    .step_cw       (step_cw),
    .step_ccw      (step_ccw),
    .illegal       (illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int n_cw = 0, n_ccw = 0, n_ill = 0, n_upd = 0, n_unexp = 0;
  int s_cw = 0, s_ccw = 0, s_ill = 0, s_upd = 0;
  int last_upd_cyc = 0;
  int edge_cyc = 0;
  logic [PHASE_W-1:0] exp_q[$];
  longint m_word = W_INIT;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (step_cw)  n_cw++;
    if (step_ccw) n_ccw++;
    if (illegal)  n_ill++;
    if (tuning_update) begin
      n_upd++;
      last_upd_cyc = cyc;
      if (exp_q.size() > 0)
        chk("sb_word", 64'(tuning_word), 64'(exp_q.pop_front()));
      else
        n_unexp++;
    end
  end

  function automatic longint sat(input longint v);
    if (v > W_MAX) return W_MAX;
    if (v < W_MIN) return W_MIN;
    return v;
  endfunction

  task automatic expect_word(input longint v);
    longint nv;
    nv = sat(v);
    if (nv != m_word) exp_q.push_back(nv[PHASE_W-1:0]);
    m_word = nv;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_pins(input logic a, input logic b, input int hold);
    fq_ck = a;
    fq_dt = b;
    tick(hold);
  endtask

  task automatic snap();
    s_cw = n_cw; s_ccw = n_ccw; s_ill = n_ill; s_upd = n_upd;
  endtask

  task automatic chk_events(input string tag, input int cw, input int ccw, input int ill, input int upd);
    chk({tag, "_cw"},  64'(n_cw - s_cw),   64'(cw));
    chk({tag, "_ccw"}, 64'(n_ccw - s_ccw), 64'(ccw));
    chk({tag, "_ill"}, 64'(n_ill - s_ill), 64'(ill));
    chk({tag, "_upd"}, 64'(n_upd - s_upd), 64'(upd));
  endtask

  task automatic detent(input bit cw);
    expect_word(cw ? m_word + W_STEP : m_word - W_STEP);
    if (cw) begin
      drive_pins(1, 0, HOLD); drive_pins(0, 0, HOLD); drive_pins(0, 1, HOLD); drive_pins(1, 1, HOLD);
    end else begin
      drive_pins(0, 1, HOLD); drive_pins(0, 0, HOLD); drive_pins(1, 0, HOLD); drive_pins(1, 1, HOLD);
    end
  endtask

  task automatic preset(input longint v);
    preset_word = v[PHASE_W-1:0];
    preset_load = 1'b1;
    expect_word(v);
    tick(1);
    preset_load = 1'b0;
    tick(3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

    // 1: reset values, valid from first cycle, idle encoder
    tick(3);
    chk("rst_word", 64'(tuning_word), 64'(W_INIT));
    chk("rst_valid", 64'(tuning_valid), 64'd0);
    chk("rst_pulses", 64'({step_cw, step_ccw, illegal, tuning_update}), 64'd0);
    reset = 1'b0;
    tick(1);
    chk("valid_cycle1", 64'(tuning_valid), 64'd1);
    snap();
    tick(10000);
    chk("t1_word", 64'(tuning_word), 64'(W_INIT));
    chk("t1_valid", 64'(tuning_valid), 64'd1);
    chk_events("t1", 0, 0, 0, 0);

    // 2: one CW detent with exact latency from the final pin edge
    snap();
    drive_pins(1, 0, HOLD); drive_pins(0, 0, HOLD); drive_pins(0, 1, HOLD);
    expect_word(m_word + W_STEP);
    fq_ck = 1'b1;
    fq_dt = 1'b1;
    edge_cyc = cyc;
    tick(HOLD);
    chk("t2_latency", 64'(last_upd_cyc - edge_cyc), 64'(LAT));
    chk("t2_word", 64'(tuning_word), 64'd8396997);
    chk_events("t2", 1, 0, 0, 1);

    // 3: short glitch, then a partial turn that reverses
    snap();
    fq_ck = 1'b0;
    tick(1000);
    fq_ck = 1'b1;
    tick(HOLD);
    drive_pins(1, 0, HOLD); drive_pins(1, 1, HOLD);
    chk_events("t3", 0, 0, 0, 0);
    chk("t3_word", 64'(tuning_word), 64'd8396997);

    // 4: saturation at both limits and preset clamping
    preset(4450000);
    chk("t4_preset", 64'(tuning_word), 64'd4450000);
    snap();
    detent(0);
    chk("t4_ccw1", 64'(tuning_word), 64'(W_MIN));
    detent(0);
    chk("t4_ccw2", 64'(tuning_word), 64'(W_MIN));
    chk_events("t4_ccw", 0, 2, 0, 1);
    preset(14255000);
    snap();
    detent(1); detent(1); detent(1);
    chk("t4_cw3", 64'(tuning_word), 64'(W_MAX));
    chk_events("t4_cw", 3, 0, 0, 1);
    snap();
    preset(14260634);
    chk_events("t4_same", 0, 0, 0, 0);
    preset(1000);
    chk("t4_clamp_lo", 64'(tuning_word), 64'(W_MIN));
    preset(30000000);
    chk("t4_clamp_hi", 64'(tuning_word), 64'(W_MAX));

    // 5: both pins switched together, then a normal detent
    preset(10000000);
    snap();
    drive_pins(0, 0, HOLD);
    chk_events("t5_jump", 0, 0, 1, 0);
    snap();
    drive_pins(0, 1, HOLD); drive_pins(1, 1, HOLD);
    chk_events("t5_return", 0, 0, 0, 0);
    snap();
    detent(1);
    chk("t5_word", 64'(tuning_word), 64'd10008389);
    chk_events("t5_cw", 1, 0, 0, 1);

    // 6a: preset lands in the same cycle as a step pulse
    preset(10000000);
    snap();
    drive_pins(1, 0, HOLD); drive_pins(0, 0, HOLD); drive_pins(0, 1, HOLD);
    fq_ck = 1'b1;
    fq_dt = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (step_cw) found = 1'b1;
    end
    chk("t6_step_seen", 64'(found), 64'd1);
    preset_word = 27'd9000000;
    preset_load = 1'b1;
    expect_word(9000000);
    @(posedge clk);
    #1;
    preset_load = 1'b0;
    tick(HOLD);
    chk("t6_race_word", 64'(tuning_word), 64'd9000000);
    chk_events("t6_race", 1, 0, 0, 1);

    // 6b: reset half way through a detent
    drive_pins(1, 0, HOLD); drive_pins(0, 0, HOLD);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    m_word = W_INIT;
    chk("t6_rst_word", 64'(tuning_word), 64'(W_INIT));
    chk("t6_rst_valid", 64'(tuning_valid), 64'd1);
    snap();
    drive_pins(0, 1, HOLD); drive_pins(1, 1, HOLD);
    chk("t6_post_cw", 64'(n_cw - s_cw), 64'd0);
    chk("t6_post_ccw", 64'(n_ccw - s_ccw), 64'd0);
    chk("t6_post_upd", 64'(n_upd - s_upd), 64'd0);
    chk("t6_post_word", 64'(tuning_word), 64'(W_INIT));

    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    chk("sb_unexpected", 64'(n_unexp), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
